// File: rtl/signed_display_scanner_pkg.sv
// Shared constants and types for the signed 4-digit multiplexed display scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package signed_display_scanner_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   // Any code above 9 decodes to a blank digit.
   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef enum logic {
      IDLE,
      CONVERT
   } state_t;

endpackage

// File: rtl/signed_display_scanner_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9 blank.
module bcd_to_seg7
   import signed_display_scanner_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/signed_display_scanner.sv
// Accepts a signed result, converts its magnitude to 3 BCD digits by sequential
// double-dabble, and time-multiplexes them onto a 4-digit active-low display.
module signed_display_scanner
   import signed_display_scanner_pkg::*;
#(
   parameter int DATA_W      = 10,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_value,
   output logic              load_ready,
   output logic [1:0]        select,
   output logic              neg_flag,
   output logic [3:0]        an,
   output logic [6:0]        seg
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = 12;
   localparam int DD_W  = BCD_W + DATA_W;

   state_t            state_reg;
   logic [DATA_W-1:0] mag_reg;
   logic [BCD_W-1:0]  bcd_reg;
   logic [BIT_W-1:0]  bit_cnt_reg;
   logic              sign_reg;
   logic [BCD_W-1:0]  disp_reg;
   logic              disp_neg_reg;
   logic              load_ready_reg;
   logic [CNT_W-1:0]  refresh_cnt_reg;
   logic [1:0]        select_reg;
   logic [3:0]        an_reg;
   logic [6:0]        seg_reg;

   logic [BCD_W-1:0]  bcd_adj;
   logic [DD_W-1:0]   dd_shift;
   logic [BCD_W-1:0]  bcd_next;
   logic [DATA_W-1:0] mag_next;
   logic [DATA_W-1:0] mag_in;
   logic              commit;
   logic              wrap;
   logic [1:0]        select_next;
   logic [BCD_W-1:0]  digits_next;
   logic [3:0]        digit_mux;
   logic [6:0]        seg_next;

   // Add-3 correction on every scratch nibble before the shift.
   genvar gi;
   generate
      for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign dd_shift = {bcd_adj, mag_reg} << 1;
   assign bcd_next = dd_shift[DD_W-1 -: BCD_W];
   assign mag_next = dd_shift[DATA_W-1:0];

   // -512 maps to 512 because the unsigned interpretation of the negation is exact.
   assign mag_in = load_value[DATA_W-1] ? (~load_value + DATA_W'(1)) : load_value;

   assign commit      = (state_reg == CONVERT) && (bit_cnt_reg == BIT_W'(DATA_W - 1));
   assign wrap        = (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1));
   assign select_next = wrap ? select_reg + 2'd1 : select_reg;
   assign digits_next = commit ? bcd_next : disp_reg;

   always_comb begin
      digit_mux = BCD_BLANK;
      case (select_next)
         2'd0: digit_mux = digits_next[3:0];
         2'd1: digit_mux = ((BLANK_LZ != 0) && (digits_next[11:4] == 8'd0)) ?
                           BCD_BLANK : digits_next[7:4];
         2'd2: digit_mux = ((BLANK_LZ != 0) && (digits_next[11:8] == 4'd0)) ?
                           BCD_BLANK : digits_next[11:8];
         default: digit_mux = BCD_BLANK;
      endcase
   end

   bcd_to_seg7 u_bcd_to_seg7 (
      .bcd (digit_mux),
      .seg (seg_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         mag_reg        <= '0;
         bcd_reg        <= '0;
         bit_cnt_reg    <= '0;
         sign_reg       <= 1'b0;
         disp_reg       <= '0;
         disp_neg_reg   <= 1'b0;
         load_ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (load_valid && load_ready_reg) begin
                  sign_reg       <= load_value[DATA_W-1];
                  mag_reg        <= mag_in;
                  bcd_reg        <= '0;
                  bit_cnt_reg    <= '0;
                  load_ready_reg <= 1'b0;
                  state_reg      <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_reg     <= bcd_next;
               mag_reg     <= mag_next;
               bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
               if (commit) begin
                  disp_reg       <= bcd_next;
                  disp_neg_reg   <= sign_reg;
                  load_ready_reg <= 1'b1;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // an/seg follow select_next and digits_next so they move on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt_reg <= '0;
         select_reg      <= 2'd0;
         an_reg          <= 4'b1110;
         seg_reg         <= SEG_0;
      end else begin
         refresh_cnt_reg <= wrap ? '0 : refresh_cnt_reg + CNT_W'(1);
         select_reg      <= select_next;
         an_reg          <= ~(4'b0001 << select_next);
         seg_reg         <= seg_next;
      end
   end

   assign load_ready = load_ready_reg;
   assign select     = select_reg;
   assign neg_flag   = disp_neg_reg;
   assign an         = an_reg;
   assign seg        = seg_reg;

endmodule

// File: tb/tb_signed_display_scanner.sv
// Randomised and directed bench for signed_display_scanner, compared every cycle
// against a decimal-arithmetic model of what the display must show.
module tb_signed_display_scanner;

   localparam int DATA_W = 10;
   localparam int RDIV   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_value = '0;

   logic       ready_a, neg_a, ready_b, neg_b;
   logic [1:0] sel_a, sel_b;
   logic [3:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   signed_display_scanner #(.DATA_W(DATA_W), .REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_value(load_value),
      .load_ready(ready_a), .select(sel_a), .neg_flag(neg_a), .an(an_a), .seg(seg_a)
   );

   signed_display_scanner #(.DATA_W(DATA_W), .REFRESH_DIV(RDIV), .BLANK_LZ(0)) dut_nz (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_value(load_value),
      .load_ready(ready_b), .select(sel_b), .neg_flag(neg_b), .an(an_b), .seg(seg_b)
   );

   // Model: shown value, pending value, cycles left in conversion, ticks since reset.
   int m_disp    = 0;
   int m_pending = 0;
   int m_left    = 0;
   bit m_ready   = 1'b1;
   int m_ticks   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_disp  <= 0;
         m_left  <= 0;
         m_ready <= 1'b1;
         m_ticks <= 0;
      end else begin
         m_ticks <= m_ticks + 1;
         if (!m_ready) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_disp  <= m_pending;
               m_ready <= 1'b1;
            end
         end else if (load_valid) begin
            m_pending <= $signed(load_value);
            m_left    <= DATA_W;
            m_ready   <= 1'b0;
         end
      end
   end

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Digit k>0 is a leading zero exactly when |v| < 10^k.
   function automatic logic [6:0] exp_seg(input int v, input int sel, input bit blz);
      int a;
      int p10;
      a = (v < 0) ? -v : v;
      if (sel == 3) return 7'b1111111;
      p10 = (sel == 0) ? 1 : ((sel == 1) ? 10 : 100);
      if (blz && sel > 0 && a < p10) return 7'b1111111;
      return pat((a / p10) % 10);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      int s;
      s = (m_ticks / RDIV) % 4;
      chk("select_a", sel_a, s);
      chk("an_a", an_a, 4'b1111 & ~(4'b0001 << s));
      chk("seg_a", seg_a, exp_seg(m_disp, s, 1'b1));
      chk("neg_a", neg_a, m_disp < 0);
      chk("ready_a", ready_a, m_ready);
      chk("select_b", sel_b, s);
      chk("an_b", an_b, 4'b1111 & ~(4'b0001 << s));
      chk("seg_b", seg_b, exp_seg(m_disp, s, 1'b0));
      chk("neg_b", neg_b, m_disp < 0);
      chk("ready_b", ready_b, m_ready);
   end

   // Present v and hold it until accepted; waited = negedges spent waiting.
   task automatic do_load(input int v, output int waited);
      int n;
      n = 0;
      load_valid = 1'b1;
      load_value = v[DATA_W-1:0];
      @(negedge clk);
      while (!ready_a && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail_bound("accept_timeout");
      waited = n;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      $display("load %0d accepted after %0d wait cycles", v, n);
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         if (!ready_a) cyc++;
      end while (!ready_a && cyc < 200);
      if (cyc >= 200) fail_bound("ready_timeout");
   endtask

   task automatic sel_lit(input string name, input int k, input logic [6:0] ea,
                          input logic [6:0] eb, input logic eneg);
      int n;
      n = 0;
      @(negedge clk);
      while (sel_a != 2'(k) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) fail_bound({name, "_sel_timeout"});
      chk({name, "_lit_a"}, seg_a, ea);
      chk({name, "_lit_b"}, seg_b, eb);
      chk({name, "_lit_neg"}, neg_a, eneg);
   endtask

   task automatic show4(input string name, input logic [6:0] a0, input logic [6:0] a1,
                        input logic [6:0] a2, input logic [6:0] b1, input logic [6:0] b2,
                        input logic eneg);
      sel_lit({name, "_s0"}, 0, a0, a0, eneg);
      sel_lit({name, "_s1"}, 1, a1, b1, eneg);
      sel_lit({name, "_s2"}, 2, a2, b2, eneg);
      sel_lit({name, "_s3"}, 3, 7'b1111111, 7'b1111111, eneg);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cyc;
      int v;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", an_a, 4'b1110);
      chk("rst_seg", seg_a, 7'b1000000);
      chk("rst_ready", ready_a, 1'b1);
      chk("rst_neg", neg_a, 1'b0);
      chk("rst_select", sel_a, 2'd0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("seq_sel1", sel_a, 2'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("seq_sel2", sel_a, 2'd2);

      do_load(123, w);
      wait_ready(cyc);
      chk("ready_low_cycles", cyc, 10);
      show4("v123", 7'b0110000, 7'b0100100, 7'b1111001, 7'b0100100, 7'b1111001, 1'b0);

      do_load(-512, w);
      wait_ready(cyc);
      show4("vm512", 7'b0100100, 7'b1111001, 7'b0010010, 7'b1111001, 7'b0010010, 1'b1);

      do_load(-1, w);
      wait_ready(cyc);
      show4("vm1", 7'b1111001, 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000, 1'b1);

      do_load(0, w);
      wait_ready(cyc);
      show4("v0", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000, 1'b0);

      do_load(7, w);
      wait_ready(cyc);
      show4("v7", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000, 1'b0);

      // Second value offered during a conversion must wait for load_ready.
      do_load(300, w);
      do_load(45, w);
      chk("held_wait", w, 10);
      wait_ready(cyc);
      show4("v45", 7'b0010010, 7'b0011001, 7'b1111111, 7'b0011001, 7'b1000000, 1'b0);

      for (int i = 0; i < 24; i++) begin
         v = int'($urandom_range(0, 1023)) - 512;
         do_load(v, w);
         repeat ($urandom_range(0, 25)) @(posedge clk);
         #1;
      end
      wait_ready(cyc);
      repeat (20) @(posedge clk);
      #1;

      do_load(250, w);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", ready_a, 1'b1);
      chk("midrst_seg", seg_a, 7'b1000000);
      chk("midrst_an", an_a, 4'b1110);
      chk("midrst_select", sel_a, 2'd0);
      chk("midrst_neg", neg_a, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      show4("after_rst", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
